// File: rtl/dut_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dut_param_pkg
// Description : Shared parameter defaults and FSM state encoding for the
//               flkc_dxi_feeder block.
//               Contents:
//                 c_P_K        - default pixel width in bits
//                 c_P_CH_NUM   - default pixels per DXI beat
//                 c_P_PIPELINE - default correction pipeline depth
//                 c_P_CNT_BIT  - default line/row counter width
//                 state_t      - feeder FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package dut_param_pkg;

  localparam int c_P_K        = 14;
  localparam int c_P_CH_NUM   = 2;
  localparam int c_P_PIPELINE = 2;
  localparam int c_P_CNT_BIT  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage : dut_param_pkg
`default_nettype wire

// File: rtl/flkc_ena_shift.sv
`default_nettype none
// ============================================================================
// Module      : flkc_ena_shift
// Description : Enable shift chain feeding the correction core. Bit 0 takes
//               the accept strobe, each later bit copies its predecessor
//               every cycle, and the valid tap copies the last bit.
//               Ports:
//                 clk        - clock, rising edge
//                 rst        - synchronous active-high reset
//                 i_ena_in   - accept strobe shifted into bit 0
//                 o_ena_vec  - per-stage enables (P_WIDTH bits)
//                 o_valid    - one cycle after the last stage
// Revision    : 1.0 - initial release
// ============================================================================
module flkc_ena_shift #(
  parameter int P_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ena_in,
  output logic [P_WIDTH-1:0] o_ena_vec,
  output logic               o_valid
);

  logic [P_WIDTH-1:0] vec_q;
  logic [P_WIDTH-1:0] vec_d;
  logic               valid_q;
  logic               valid_d;

  generate
    if (P_WIDTH == 1) begin : g_single
      always_comb begin
        vec_d = i_ena_in;
      end
    end else begin : g_multi
      always_comb begin
        vec_d = {vec_q[P_WIDTH-2:0], i_ena_in};
      end
    end
  endgenerate

  always_comb begin
    valid_d = vec_q[P_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      valid_q <= valid_d;
    end
  end

  assign o_ena_vec = vec_q;
  assign o_valid   = valid_q;

endmodule : flkc_ena_shift
`default_nettype wire

// File: rtl/flkc_dxi_feeder.sv
`default_nettype none
// ============================================================================
// Module      : flkc_dxi_feeder
// Description : Frames upstream pixel beats into lines and rows for the DXI
//               correction core. Registers each accepted beat with its row
//               parity, generates the per-stage enable chain and the output
//               valid strobe, inserts horizontal blanking between lines and
//               drains the pipeline before signalling frame completion.
//               Ports:
//                 clk, rst              - clock / synchronous active-high reset
//                 start                 - one-cycle frame start pulse
//                 cfg_line_len          - beats per line
//                 cfg_frame_h           - lines per frame
//                 cfg_hblank            - idle cycles after each non-last line
//                 cfg_y_lsb0            - row parity of the first line
//                 s_valid/s_ready/s_data- upstream beat handshake
//                 o_PIXELS, o_Y_LSB     - registered beat and its row parity
//                 o_ENA_VEC             - per-stage enables
//                 o_OUTPUT_VALID        - valid correction-core output beat
//                 o_busy                - frame in progress
//                 o_frame_done          - pulse after last output beat
//                 o_cfg_err             - pulse on start with zero geometry
// Revision    : 1.0 - initial release
// ============================================================================
module flkc_dxi_feeder
  import dut_param_pkg::*;
#(
  parameter int P_K        = c_P_K,
  parameter int P_CH_NUM   = c_P_CH_NUM,
  parameter int P_PIPELINE = c_P_PIPELINE,
  parameter int P_CNT_BIT  = c_P_CNT_BIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [P_CNT_BIT-1:0]    cfg_line_len,
  input  logic [P_CNT_BIT-1:0]    cfg_frame_h,
  input  logic [7:0]              cfg_hblank,
  input  logic                    cfg_y_lsb0,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [P_K*P_CH_NUM-1:0] s_data,
  output logic [P_K*P_CH_NUM-1:0] o_PIXELS,
  output logic [P_PIPELINE-1:0]   o_ENA_VEC,
  output logic                    o_Y_LSB,
  output logic                    o_OUTPUT_VALID,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_cfg_err
);

  localparam int                   c_DW         = P_K * P_CH_NUM;
  localparam logic [P_CNT_BIT-1:0] c_ONE        = 1;
  // DRAIN covers the enable chain plus the valid tap.
  localparam logic [7:0]           c_DRAIN_LAST = 8'(P_PIPELINE);

  state_t               state_q, state_d;
  logic [P_CNT_BIT-1:0] len_q, len_d;
  logic [P_CNT_BIT-1:0] h_q, h_d;
  logic [7:0]           hb_q, hb_d;
  logic [P_CNT_BIT-1:0] beat_q, beat_d;
  logic [P_CNT_BIT-1:0] row_q, row_d;
  logic                 par_q, par_d;
  // Shared by HBLANK and DRAIN; never needed in both at once.
  logic [7:0]           wait_q, wait_d;
  logic [c_DW-1:0]      pix_q, pix_d;
  logic                 ylsb_q, ylsb_d;
  logic                 frame_done_q, frame_done_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 w_accept;
  logic                 w_line_last_beat;
  logic                 w_frame_last_row;

  assign s_ready          = (state_q == LINE);
  assign w_accept         = s_valid && s_ready;
  // len_q/h_q are never zero once latched, so the subtraction cannot wrap.
  assign w_line_last_beat = (beat_q == (len_q - c_ONE));
  assign w_frame_last_row = (row_q == (h_q - c_ONE));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    h_d          = h_q;
    hb_d         = hb_q;
    beat_d       = beat_q;
    row_d        = row_q;
    par_d        = par_q;
    wait_d       = wait_q;
    pix_d        = pix_q;
    ylsb_d       = ylsb_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;

    if (w_accept) begin
      pix_d  = s_data;
      ylsb_d = par_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_line_len != '0) && (cfg_frame_h != '0)) begin
            state_d = LINE;
            len_d   = cfg_line_len;
            h_d     = cfg_frame_h;
            hb_d    = cfg_hblank;
            par_d   = cfg_y_lsb0;
            beat_d  = '0;
            row_d   = '0;
            wait_d  = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      LINE: begin
        if (w_accept) begin
          if (w_line_last_beat) begin
            beat_d = '0;
            row_d  = row_q + c_ONE;
            par_d  = ~par_q;
            wait_d = '0;
            if (w_frame_last_row) begin
              state_d = DRAIN;
            end else if (hb_q != 8'd0) begin
              state_d = HBLANK;
            end
          end else begin
            beat_d = beat_q + c_ONE;
          end
        end
      end

      HBLANK: begin
        if (wait_q == (hb_q - 8'd1)) begin
          state_d = LINE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      DRAIN: begin
        // Leaving DRAIN lines the done pulse up with the cycle after the
        // last beat's output valid.
        if (wait_q == c_DRAIN_LAST) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          wait_d       = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      h_q          <= '0;
      hb_q         <= '0;
      beat_q       <= '0;
      row_q        <= '0;
      par_q        <= 1'b0;
      wait_q       <= '0;
      pix_q        <= '0;
      ylsb_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      h_q          <= h_d;
      hb_q         <= hb_d;
      beat_q       <= beat_d;
      row_q        <= row_d;
      par_q        <= par_d;
      wait_q       <= wait_d;
      pix_q        <= pix_d;
      ylsb_q       <= ylsb_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  flkc_ena_shift #(
    .P_WIDTH (P_PIPELINE)
  ) u_ena_shift (
    .clk       (clk),
    .rst       (rst),
    .i_ena_in  (w_accept),
    .o_ena_vec (o_ENA_VEC),
    .o_valid   (o_OUTPUT_VALID)
  );

  assign o_PIXELS     = pix_q;
  assign o_Y_LSB      = ylsb_q;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = frame_done_q;
  assign o_cfg_err    = cfg_err_q;

endmodule : flkc_dxi_feeder
`default_nettype wire

// File: tb/tb_flkc_dxi_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_flkc_dxi_feeder
// Description : Self-checking bench for flkc_dxi_feeder. Frames are run
//               against a reference model that derives each beat's expected
//               parity from its index in the frame and the line geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flkc_dxi_feeder;

  localparam int c_K    = 14;
  localparam int c_CH   = 2;
  localparam int c_PIPE = 2;
  localparam int c_CB   = 12;
  localparam int c_DW   = c_K * c_CH;

  logic            clk;
  logic            rst;
  logic            start;
  logic [c_CB-1:0] cfg_line_len;
  logic [c_CB-1:0] cfg_frame_h;
  logic [7:0]      cfg_hblank;
  logic            cfg_y_lsb0;
  logic            s_valid;
  logic            s_ready;
  logic [c_DW-1:0] s_data;
  logic [c_DW-1:0] o_PIXELS;
  logic [c_PIPE-1:0] o_ENA_VEC;
  logic            o_Y_LSB;
  logic            o_OUTPUT_VALID;
  logic            o_busy;
  logic            o_frame_done;
  logic            o_cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  flkc_dxi_feeder #(
    .P_K        (c_K),
    .P_CH_NUM   (c_CH),
    .P_PIPELINE (c_PIPE),
    .P_CNT_BIT  (c_CB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_line_len   (cfg_line_len),
    .cfg_frame_h    (cfg_frame_h),
    .cfg_hblank     (cfg_hblank),
    .cfg_y_lsb0     (cfg_y_lsb0),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .o_PIXELS       (o_PIXELS),
    .o_ENA_VEC      (o_ENA_VEC),
    .o_Y_LSB        (o_Y_LSB),
    .o_OUTPUT_VALID (o_OUTPUT_VALID),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done),
    .o_cfg_err      (o_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (o_PIXELS !== '0) begin n_fail++; $display("FAIL reset o_PIXELS: got %h want 0", o_PIXELS); end
    n_checks++; if (o_ENA_VEC !== '0) begin n_fail++; $display("FAIL reset o_ENA_VEC: got %b want 0", o_ENA_VEC); end
    n_checks++; if (o_Y_LSB !== 1'b0) begin n_fail++; $display("FAIL reset o_Y_LSB: got %b want 0", o_Y_LSB); end
    n_checks++; if (o_OUTPUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset o_OUTPUT_VALID: got %b want 0", o_OUTPUT_VALID); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset o_busy: got %b want 0", o_busy); end
    n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset o_frame_done: got %b want 0", o_frame_done); end
    n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset o_cfg_err: got %b want 0", o_cfg_err); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset s_ready: got %b want 0", s_ready); end
    rst = 1'b0;
    tick();
  endtask

  // Runs one frame with random data. vprob is the percentage of cycles with
  // s_valid high; a negative vprob alternates s_valid 1,0,1,0.
  task automatic run_frame(input string tag, input int len, input int h,
                           input int hb, input bit y0, input int vprob);
    logic [c_DW-1:0] exp_d[$];
    bit              exp_p[$];
    logic [c_DW-1:0] ed;
    bit              ep;
    int acc = 0, ena_n = 0, val_n = 0, done_n = 0;
    int cyc = 0, last_val = -10, done_cyc = -10, gap = 0, budget;
    bit gap_pend = 1'b0;
    bit line_end;

    cfg_line_len = c_CB'(len);
    cfg_frame_h  = c_CB'(h);
    cfg_hblank   = 8'(hb);
    cfg_y_lsb0   = y0;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    budget = len * h * 20 + h * hb + 200;

    while (cyc < budget && !(done_n > 0 && cyc >= done_cyc + 4)) begin
      if (vprob < 0) s_valid = ((cyc % 2) == 0);
      else           s_valid = ($urandom_range(0, 99) < vprob);
      s_data   = c_DW'($urandom);
      line_end = 1'b0;
      if (s_valid && s_ready) begin
        exp_d.push_back(s_data);
        exp_p.push_back(y0 ^ (((acc / len) % 2) == 1));
        line_end = ((acc % len) == len - 1) && ((acc / len) < h - 1);
        acc++;
      end
      tick();
      cyc++;

      if (cyc == 1) begin
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b want 1", tag, o_busy); end
      end

      if (o_ENA_VEC[0] === 1'b1) begin
        ena_n++;
        if (exp_d.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL %s unexpected_beat: got ena with no accepted beat, want none", tag);
        end else begin
          ed = exp_d.pop_front();
          ep = exp_p.pop_front();
          n_checks++; if (o_PIXELS !== ed) begin n_fail++; $display("FAIL %s pixels beat %0d: got %h want %h", tag, ena_n - 1, o_PIXELS, ed); end
          n_checks++; if (o_Y_LSB !== ep) begin n_fail++; $display("FAIL %s y_lsb beat %0d: got %b want %b", tag, ena_n - 1, o_Y_LSB, ep); end
        end
      end

      if (o_OUTPUT_VALID === 1'b1) begin
        val_n++;
        last_val = cyc;
      end

      if (o_frame_done === 1'b1) begin
        done_n++;
        done_cyc = cyc;
        n_checks++; if (cyc !== last_val + 1) begin n_fail++; $display("FAIL %s done_timing: got cycle %0d want %0d", tag, cyc, last_val + 1); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b want 0", tag, o_busy); end
      end

      if (line_end) begin
        gap_pend = 1'b1;
        gap      = 0;
      end
      if (gap_pend) begin
        if (s_ready === 1'b0) begin
          gap++;
        end else begin
          gap_pend = 1'b0;
          n_checks++; if (gap !== hb) begin n_fail++; $display("FAIL %s hblank_gap: got %0d want %0d", tag, gap, hb); end
        end
      end
    end
    s_valid = 1'b0;

    if (cyc >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got no frame_done within %0d cycles, want done", tag, budget);
    end
    n_checks++; if (acc !== len * h) begin n_fail++; $display("FAIL %s accepts: got %0d want %0d", tag, acc, len * h); end
    n_checks++; if (ena_n !== len * h) begin n_fail++; $display("FAIL %s ena_pulses: got %0d want %0d", tag, ena_n, len * h); end
    n_checks++; if (val_n !== len * h) begin n_fail++; $display("FAIL %s valid_pulses: got %0d want %0d", tag, val_n, len * h); end
    n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_n); end
  endtask

  task automatic test_basic_frame();
    run_frame("basic", 4, 2, 3, 1'b0, 100);
  endtask

  task automatic test_single_beat();
    cfg_line_len = 12'd1;
    cfg_frame_h  = 12'd1;
    cfg_hblank   = 8'd0;
    cfg_y_lsb0   = 1'b1;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL single s_ready: got %b want 1", s_ready); end
    s_valid = 1'b1;
    s_data  = 28'hABCD;
    tick();
    s_valid = 1'b0;
    n_checks++; if (o_PIXELS !== 28'hABCD) begin n_fail++; $display("FAIL single pixels_t1: got %h want abcd", o_PIXELS); end
    n_checks++; if (o_ENA_VEC !== 2'b01) begin n_fail++; $display("FAIL single ena_t1: got %b want 01", o_ENA_VEC); end
    n_checks++; if (o_Y_LSB !== 1'b1) begin n_fail++; $display("FAIL single y_lsb_t1: got %b want 1", o_Y_LSB); end
    // A start during the drain must be ignored.
    cfg_frame_h = 12'd5;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    n_checks++; if (o_ENA_VEC !== 2'b10) begin n_fail++; $display("FAIL single ena_t2: got %b want 10", o_ENA_VEC); end
    n_checks++; if (o_OUTPUT_VALID !== 1'b0) begin n_fail++; $display("FAIL single valid_t2: got %b want 0", o_OUTPUT_VALID); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL single ready_drain: got %b want 0", s_ready); end
    tick();
    n_checks++; if (o_OUTPUT_VALID !== 1'b1) begin n_fail++; $display("FAIL single valid_t3: got %b want 1", o_OUTPUT_VALID); end
    n_checks++; if (o_ENA_VEC !== 2'b00) begin n_fail++; $display("FAIL single ena_t3: got %b want 00", o_ENA_VEC); end
    tick();
    n_checks++; if (o_frame_done !== 1'b1) begin n_fail++; $display("FAIL single done_t4: got %b want 1", o_frame_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single busy_t4: got %b want 0", o_busy); end
    tick();
    n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL single done_t5: got %b want 0", o_frame_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single start_ignored: got busy %b want 0", o_busy); end
  endtask

  task automatic test_stall();
    run_frame("stall", 4, 1, 0, 1'b0, -1);
    run_frame("stall2", 4, 2, 2, 1'b1, -1);
  endtask

  task automatic test_cfg_err();
    cfg_line_len = 12'd4;
    cfg_frame_h  = 12'd0;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    n_checks++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_h0 pulse: got %b want 1", o_cfg_err); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_err_h0 s_ready: got %b want 0", s_ready); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_h0 busy: got %b want 0", o_busy); end
    tick();
    n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_h0 one_cycle: got %b want 0", o_cfg_err); end
    cfg_line_len = 12'd0;
    cfg_frame_h  = 12'd2;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    n_checks++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_l0 pulse: got %b want 1", o_cfg_err); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_l0 busy: got %b want 0", o_busy); end
    tick();
  endtask

  task automatic test_rst_mid();
    int acc = 0, cyc = 0, ev = 0;
    cfg_line_len = 12'd4;
    cfg_frame_h  = 12'd2;
    cfg_hblank   = 8'd3;
    cfg_y_lsb0   = 1'b0;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    s_valid      = 1'b1;
    while (acc < 7 && cyc < 50) begin
      s_data = c_DW'($urandom);
      if (s_ready) acc++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    n_checks++; if (acc !== 7) begin n_fail++; $display("FAIL rst_mid accepts_before_rst: got %0d want 7", acc); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (o_PIXELS !== '0) begin n_fail++; $display("FAIL rst_mid pixels: got %h want 0", o_PIXELS); end
    n_checks++; if (o_ENA_VEC !== '0) begin n_fail++; $display("FAIL rst_mid ena: got %b want 0", o_ENA_VEC); end
    n_checks++; if (o_OUTPUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid valid: got %b want 0", o_OUTPUT_VALID); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", o_busy); end
    n_checks++; if (o_Y_LSB !== 1'b0) begin n_fail++; $display("FAIL rst_mid y_lsb: got %b want 0", o_Y_LSB); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_frame_done || o_OUTPUT_VALID) ev++;
    end
    n_checks++; if (ev !== 0) begin n_fail++; $display("FAIL rst_mid stale_events: got %0d want 0", ev); end
    run_frame("after_rst", 4, 2, 3, 1'b0, 100);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b", 1, 3, 0, 1'b0, 100);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_frame("rand", $urandom_range(1, 6), $urandom_range(1, 4),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(30, 100));
    end
  endtask

  task automatic test_max_len();
    run_frame("maxlen", 4095, 1, 0, 1'b1, 100);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    cfg_line_len = '0;
    cfg_frame_h  = '0;
    cfg_hblank   = '0;
    cfg_y_lsb0   = 1'b0;
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_stall();
    test_cfg_err();
    test_rst_mid();
    test_back_to_back();
    test_random();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_flkc_dxi_feeder
`default_nettype wire

// File: doc/flkc_dxi_feeder.md
FLKC_DXI_FEEDER -- requirements
Module: flkc_dxi_feeder

Interface
REQ-001 P_K, 14, pixel width in bits.
REQ-002 P_CH_NUM, 2, pixels per DXI beat.
REQ-003 P_PIPELINE, 2, correction pipeline depth; width of o_ENA_VEC.
REQ-004 P_CNT_BIT, 12, width of line/row counters and cfg_line_len/cfg_frame_h.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse; begins one frame.
REQ-008 cfg_line_len  in  P_CNT_BIT  beats per line.
REQ-009 cfg_frame_h  in  P_CNT_BIT  lines per frame.
REQ-010 cfg_hblank  in  8  idle cycles inserted after each line.
REQ-011 cfg_y_lsb0  in  1  row parity of first line.
REQ-012 s_valid / s_ready  in / out  1 / 1  upstream pixel-beat handshake.
REQ-013 s_data  in  P_K*P_CH_NUM  upstream pixel beat.
REQ-014 o_PIXELS  out  P_K*P_CH_NUM  DXI data to correction core.
REQ-015 o_ENA_VEC  out  P_PIPELINE  per-stage enables for correction core.
REQ-016 o_Y_LSB  out  1  row parity aligned with o_PIXELS.
REQ-017 o_OUTPUT_VALID  out  1  marks valid correction-core output beat.
REQ-018 o_busy, o_frame_done, o_cfg_err  out  1 each  status; done/err are one-cycle pulses.

Function
REQ-019 FSM states SHALL be IDLE, LINE, HBLANK, DRAIN.
REQ-020 IDLE->LINE on start with cfg_line_len!=0 and cfg_frame_h!=0; all cfg_* latched that cycle; row parity := cfg_y_lsb0.
REQ-021 start with cfg_line_len==0 or cfg_frame_h==0 SHALL stay IDLE and pulse o_cfg_err next cycle.
REQ-022 start while not IDLE SHALL be ignored.
REQ-023 s_ready SHALL be 1 only in LINE; beat accepted when s_valid&&s_ready.
REQ-024 Accepted beat: o_PIXELS <= s_data, o_ENA_VEC[0] <= 1, o_Y_LSB <= row parity, next cycle (latency 1); otherwise o_ENA_VEC[0] <= 0, o_PIXELS holds.
REQ-025 o_ENA_VEC[i] <= o_ENA_VEC[i-1] for i>=1 every cycle; o_OUTPUT_VALID <= o_ENA_VEC[P_PIPELINE-1] (total P_PIPELINE+1 cycles accept-to-valid).
REQ-026 Beat counter increments per accept; on accept of beat cfg_line_len-1: counter := 0, row counter +1, row parity toggles.
REQ-027 After final beat of non-last line: LINE->HBLANK if cfg_hblank!=0 (stay exactly cfg_hblank cycles, s_ready=0), else remain LINE with no gap.
REQ-028 After final beat of line cfg_frame_h-1: LINE->DRAIN; DRAIN lasts P_PIPELINE+1 cycles, then ->IDLE with o_frame_done pulsed in the cycle after o_OUTPUT_VALID of last beat.
REQ-029 Upstream stalls (s_valid=0) in LINE SHALL insert bubbles only; counters, parity unchanged.
REQ-030 o_busy SHALL be 1 in every state except IDLE.
REQ-031 Counters SHALL use P_CNT_BIT bits; max cfg values 2^P_CNT_BIT-1 SHALL work without wrap error.

Reset
REQ-032 rst high at clock edge SHALL force IDLE, counters 0, s_ready 0, o_PIXELS 0, o_ENA_VEC 0, o_Y_LSB 0, o_OUTPUT_VALID 0, o_busy 0, o_frame_done 0, o_cfg_err 0.
REQ-033 rst mid-frame SHALL discard in-flight beats; no o_frame_done pulse; start accepted first cycle after rst low.

Structure
REQ-034 P_K, P_CH_NUM, P_PIPELINE, P_CNT_BIT defaults and FSM state enum SHALL live in dut_param_pkg.
REQ-035 Enable shift chain SHALL be sub-module flkc_ena_shift (width P_PIPELINE, output valid tap).

Verification
REQ-036 line_len=4, frame_h=2, hblank=3, y_lsb0=0, s_valid=1 -> 8 ena pulses, o_Y_LSB 0,0,0,0 then 1,1,1,1, 3-cycle gap, frame_done once.
REQ-037 Single beat 0xABCD accepted at cycle t, P_PIPELINE=2 -> o_PIXELS=0xABCD at t+1, o_ENA_VEC=01,10 at t+1,t+2, o_OUTPUT_VALID at t+3.
REQ-038 s_valid toggling 1,0,1,0 -> beats counted only on accept; line ends after 4 accepts, parity toggles once.
REQ-039 start with cfg_frame_h=0 -> o_cfg_err pulse, s_ready stays 0, o_busy 0.
REQ-040 rst asserted after 3 beats of line 1 -> all outputs 0 next edge, no frame_done; new start runs full frame correctly.
REQ-041 hblank=0, line_len=1, frame_h=3 -> 3 back-to-back accepts, parity 0,1,0, frame_done after drain.
